// File: rtl/npu_pkg.sv
// Shared NPU types: drain FSM states, output FIFO entry layout and the requantizer used
// by the result drain and later writeback stages.
package npu_pkg;

    localparam int unsigned NPU_DATA_W  = 32;
    localparam int unsigned NPU_OUT_W   = 8;
    localparam int unsigned NPU_LANE_W  = 2;
    localparam int unsigned NPU_SHIFT_W = 5;

    typedef enum logic [0:0] {
        IDLE,
        PROCESS
    } drain_state_e;

    typedef struct packed {
        logic signed [NPU_OUT_W-1:0]  data;
        logic        [NPU_LANE_W-1:0] lane;
        logic                         last;
    } drain_entry_t;

    typedef struct packed {
        logic signed [NPU_OUT_W-1:0] r;
        logic                        sat;
    } requant_t;

    // Optional ReLU, round-half-up arithmetic right shift, then signed saturation.
    // One guard bit above DATA_W keeps the rounding add from overflowing.
    function automatic requant_t requant(input logic signed [NPU_DATA_W-1:0]  v,
                                         input logic        [NPU_SHIFT_W-1:0] s,
                                         input logic                          relu);
        requant_t                     res;
        logic signed [NPU_DATA_W:0]   x;
        logic signed [NPU_DATA_W:0]   rnd;
        logic signed [NPU_DATA_W:0]   max_v;
        logic signed [NPU_DATA_W:0]   min_v;
        logic        [NPU_SHIFT_W-1:0] se;

        x = (relu && v[NPU_DATA_W-1]) ? '0 : {v[NPU_DATA_W-1], v};
        se = (32'(s) > NPU_DATA_W - 1) ? NPU_SHIFT_W'(NPU_DATA_W - 1) : s;
        rnd = '0;
        if (se != '0) begin
            rnd[se - 1'b1] = 1'b1;
        end
        x = (x + rnd) >>> se;

        max_v = '0;
        max_v[NPU_OUT_W-2:0] = '1;
        min_v = '1;
        min_v[NPU_OUT_W-2:0] = '0;

        if (x > max_v) begin
            res.r   = max_v[NPU_OUT_W-1:0];
            res.sat = 1'b1;
        end else if (x < min_v) begin
            res.r   = min_v[NPU_OUT_W-1:0];
            res.sat = 1'b1;
        end else begin
            res.r   = x[NPU_OUT_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only when a
// pop happens on the same edge. The head reads as zero while empty.
module npu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/pe_result_drain.sv
// Captures one row of PE accumulator results, requantizes each valid lane in ascending
// lane order and streams the results out through a small FIFO.
module pe_result_drain
    import npu_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned SHIFT_W    = 5,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LANE_W    = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] pe_result,
    input  logic [LANES-1:0]        pe_valid,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic                    relu_en,
    output logic                    busy,
    output logic [OUT_W-1:0]        out_data,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic                    drop_err,
    input  logic                    err_clr
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(drain_entry_t);

    drain_state_e            state_q, state_d;
    logic [LANES*DATA_W-1:0] result_q;
    logic [LANES-1:0]        mask_q, mask_d;
    logic [LANES-1:0]        mask_rest;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    relu_q;
    logic                    sat_q, sat_d;
    logic                    drop_q, drop_d;

    logic [LANE_W-1:0]       sel;
    logic                    last;
    logic                    row_in;
    logic                    capture;
    logic                    can_push;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [ENTRY_W-1:0]      fifo_dout;
    requant_t                q;
    drain_entry_t            push_entry;
    drain_entry_t            head;

    // Lowest-index lane still pending in the captured mask.
    always_comb begin
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel = LANE_W'(i);
            end
        end
    end

    assign mask_rest = mask_q & ~(LANES'(1) << sel);
    assign last      = (mask_rest == '0);
    assign q         = requant(result_q[sel*DATA_W +: DATA_W], shift_q, relu_q);

    always_comb begin
        push_entry      = '0;
        push_entry.data = q.r;
        push_entry.lane = sel;
        push_entry.last = last;
    end

    assign row_in    = |pe_valid;
    assign capture   = (state_q == IDLE) && row_in;
    assign fifo_pop  = !fifo_empty && out_ready;
    assign can_push  = !fifo_full || fifo_pop;
    assign fifo_push = (state_q == PROCESS) && can_push;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (row_in) begin
                    mask_d  = pe_valid;
                    state_d = PROCESS;
                end
            end
            PROCESS: begin
                busy = 1'b1;
                if (can_push) begin
                    mask_d = mask_rest;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: a set on the same edge as err_clr wins.
    always_comb begin
        sat_d  = sat_q;
        drop_d = drop_q;
        if (err_clr) begin
            sat_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (fifo_push && q.sat) begin
            sat_d = 1'b1;
        end
        if ((state_q == PROCESS) && row_in) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            result_q <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            sat_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
            if (capture) begin
                result_q <= pe_result;
                shift_q  <= shift;
                relu_q   <= relu_en;
            end
        end
    end

    npu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (push_entry),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head      = drain_entry_t'(fifo_dout);
    assign out_data  = head.data;
    assign out_lane  = head.lane;
    assign out_last  = head.last;
    assign out_valid = !fifo_empty;
    assign sat_flag  = sat_q;
    assign drop_err  = drop_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CNT_W'(FIFO_DEPTH));

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(head)));

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: a vector table for the requant datapath plus
// hand-written sequences for latency, backpressure, drop and mid-row reset.
module tb_pe_result_drain;

    logic         clk;
    logic         rst;
    logic [127:0] pe_result;
    logic [3:0]   pe_valid;
    logic [4:0]   shift;
    logic         relu_en;
    logic         busy;
    logic [7:0]   out_data;
    logic [1:0]   out_lane;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         sat_flag;
    logic         drop_err;
    logic         err_clr;

    pe_result_drain #(
        .LANES      (4),
        .DATA_W     (32),
        .OUT_W      (8),
        .SHIFT_W    (5),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pe_result (pe_result),
        .pe_valid  (pe_valid),
        .shift     (shift),
        .relu_en   (relu_en),
        .busy      (busy),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .drop_err  (drop_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] l;
        logic       last;
    } cap_t;

    typedef struct packed {
        logic [3:0][31:0] v;
        logic [3:0]       m;
        logic [4:0]       s;
        logic             r;
        logic [2:0]       n;
        logic [3:0][7:0]  ed;
        logic [3:0][1:0]  el;
        logic             sat;
    } vec_t;

    cap_t cap_q[$];
    vec_t vecs [9];
    int   checks = 0;
    int   errors = 0;

    // Every accepted output beat, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            cap_q.push_back({out_data, out_lane, out_last});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input logic [3:0][31:0] v, input logic [3:0] m,
                             input logic [4:0] s, input logic r);
        pe_result = v;
        pe_valid  = m;
        shift     = s;
        relu_en   = r;
        tick();
        pe_valid  = '0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    function automatic vec_t mkv(input int a0, input int a1, input int a2, input int a3,
                                 input logic [3:0] m, input logic [4:0] s, input logic r,
                                 input int n, input int e0, input int e1, input int e2,
                                 input int e3, input int l0, input int l1, input int l2,
                                 input int l3, input logic sat);
        vec_t t;
        t.v[0] = a0; t.v[1] = a1; t.v[2] = a2; t.v[3] = a3;
        t.m = m; t.s = s; t.r = r; t.n = 3'(n);
        t.ed[0] = 8'(e0); t.ed[1] = 8'(e1); t.ed[2] = 8'(e2); t.ed[3] = 8'(e3);
        t.el[0] = 2'(l0); t.el[1] = 2'(l1); t.el[2] = 2'(l2); t.el[3] = 2'(l3);
        t.sat = sat;
        return t;
    endfunction

    initial begin
        logic [3:0][31:0] row;
        int w;
        int vcnt;

        //                v0           v1           v2           v3      mask   sh  relu n
        vecs[0] = mkv(100, -5, 300, 7, 4'b1111, 5'd0, 1'b0, 4,
                      100, -5, 127, 7, 0, 1, 2, 3, 1'b1);
        vecs[1] = mkv(6, -6, 5, -200, 4'b1111, 5'd2, 1'b0, 4,
                      2, -1, 1, -50, 0, 1, 2, 3, 1'b0);
        vecs[2] = mkv(6, -6, 5, -200, 4'b1111, 5'd1, 1'b0, 4,
                      3, -3, 3, -100, 0, 1, 2, 3, 1'b0);
        vecs[3] = mkv(-5, 0, 9, -1, 4'b1111, 5'd0, 1'b1, 4,
                      0, 0, 9, 0, 0, 1, 2, 3, 1'b0);
        vecs[4] = mkv(10, 20, 30, 40, 4'b0101, 5'd0, 1'b0, 2,
                      10, 30, 0, 0, 0, 2, 0, 0, 1'b0);
        vecs[5] = mkv(-1000, 127, -128, 128, 4'b1111, 5'd0, 1'b0, 4,
                      -128, 127, -128, 127, 0, 1, 2, 3, 1'b1);
        vecs[6] = mkv(32'h40000000, 32'h80000000, 32'h3fffffff, 0, 4'b1111, 5'd31, 1'b0, 4,
                      1, -1, 0, 0, 0, 1, 2, 3, 1'b0);
        vecs[7] = mkv(0, 0, 0, -129, 4'b1000, 5'd0, 1'b0, 1,
                      -128, 0, 0, 0, 3, 0, 0, 0, 1'b1);
        vecs[8] = mkv(255, 254, -255, -256, 4'b1111, 5'd1, 1'b0, 4,
                      127, 127, -127, -128, 0, 1, 2, 3, 1'b1);

        rst = 1'b1;
        pe_result = '0;
        pe_valid = '0;
        shift = '0;
        relu_en = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_lane", 32'(out_lane), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);
        chk("rst_drop_err", 32'(drop_err), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            pulse_clr();
            cap_q.delete();
            apply_row(vecs[i].v, vecs[i].m, vecs[i].s, vecs[i].r);
            w = 0;
            while (cap_q.size() < int'(vecs[i].n) && w < 20) begin
                tick();
                w++;
            end
            repeat (3) tick();
            chk($sformatf("v%0d_count", i), cap_q.size(), 32'(vecs[i].n));
            for (int j = 0; j < int'(vecs[i].n) && j < cap_q.size(); j++) begin
                chk($sformatf("v%0d_data%0d", i, j), 32'(cap_q[j].d), 32'(vecs[i].ed[j]));
                chk($sformatf("v%0d_lane%0d", i, j), 32'(cap_q[j].l), 32'(vecs[i].el[j]));
                chk($sformatf("v%0d_last%0d", i, j), 32'(cap_q[j].last),
                    (j == int'(vecs[i].n) - 1) ? 1 : 0);
            end
            chk($sformatf("v%0d_sat", i), 32'(sat_flag), 32'(vecs[i].sat));
            chk($sformatf("v%0d_idle", i), 32'(busy), 0);
        end

        // Latency and busy duration for a sparse row.
        pulse_clr();
        cap_q.delete();
        row = {32'd40, 32'd30, 32'd20, 32'd10};
        apply_row(row, 4'b0101, 5'd0, 1'b0);
        chk("lat_valid_e0", 32'(out_valid), 0);
        chk("lat_busy_e0", 32'(busy), 1);
        tick();
        chk("lat_valid_e1", 32'(out_valid), 1);
        chk("lat_busy_e1", 32'(busy), 1);
        tick();
        chk("lat_busy_e2", 32'(busy), 0);
        chk("lat_data_e2", 32'(out_data), 30);
        chk("lat_last_e2", 32'(out_last), 1);
        repeat (3) tick();
        chk("lat_count", cap_q.size(), 2);

        // Backpressure: fill the FIFO, stall a third row, drop a fourth.
        out_ready = 1'b0;
        cap_q.delete();
        pulse_clr();
        row = {32'd4, 32'd3, 32'd2, 32'd1};
        apply_row(row, 4'b1111, 5'd0, 1'b0);
        repeat (4) tick();
        row = {32'd8, 32'd7, 32'd6, 32'd5};
        apply_row(row, 4'b1111, 5'd0, 1'b0);
        repeat (4) tick();
        chk("bp_full_busy", 32'(busy), 0);
        chk("bp_full_valid", 32'(out_valid), 1);
        row = {32'd12, 32'd11, 32'd10, 32'd9};
        apply_row(row, 4'b1111, 5'd0, 1'b0);
        repeat (3) tick();
        chk("bp_stall_busy", 32'(busy), 1);
        chk("bp_hold_data", 32'(out_data), 1);
        chk("bp_hold_lane", 32'(out_lane), 0);
        chk("bp_no_drop_yet", 32'(drop_err), 0);
        row = {32'd99, 32'd99, 32'd99, 32'd99};
        apply_row(row, 4'b1111, 5'd0, 1'b0);
        chk("bp_drop_err", 32'(drop_err), 1);
        chk("bp_drop_busy", 32'(busy), 1);
        out_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("bp_back_to_back", vcnt, 12);
        repeat (4) tick();
        chk("bp_count", cap_q.size(), 12);
        for (int j = 0; j < 12 && j < cap_q.size(); j++) begin
            chk($sformatf("bp_data%0d", j), 32'(cap_q[j].d), j + 1);
            chk($sformatf("bp_lane%0d", j), 32'(cap_q[j].l), j % 4);
            chk($sformatf("bp_last%0d", j), 32'(cap_q[j].last), (j % 4 == 3) ? 1 : 0);
        end
        chk("bp_drop_sticky", 32'(drop_err), 1);
        pulse_clr();
        chk("bp_drop_cleared", 32'(drop_err), 0);

        // Asynchronous reset in the middle of a row.
        out_ready = 1'b0;
        cap_q.delete();
        row = {32'd4, 32'd3, 32'd2, 32'd1};
        apply_row(row, 4'b1111, 5'd0, 1'b0);
        repeat (3) tick();
        chk("mr_pre_busy", 32'(busy), 1);
        chk("mr_pre_valid", 32'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_data", 32'(out_data), 0);
        chk("mr_last", 32'(out_last), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        row = {32'd24, 32'd23, 32'd22, 32'd21};
        apply_row(row, 4'b1111, 5'd0, 1'b0);
        w = 0;
        while (cap_q.size() < 4 && w < 20) begin
            tick();
            w++;
        end
        repeat (3) tick();
        chk("mr_count", cap_q.size(), 4);
        for (int j = 0; j < 4 && j < cap_q.size(); j++) begin
            chk($sformatf("mr_data%0d", j), 32'(cap_q[j].d), 21 + j);
            chk($sformatf("mr_lane%0d", j), 32'(cap_q[j].l), j);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
